// File: rtl/dmem_porta_arbiter.sv
// dmem_porta_arbiter
// Shares dmem port A between the CPU data interface and the BMEM2VGA reader.
// The CPU normally wins. A pending VGA request that keeps losing to the CPU
// is granted after a bounded number of cycles by a one-cycle FORCE_VGA state.
// Read data is returned to the requester that issued the read, using an
// owner shift register that matches the RAM read latency.

module dmem_porta_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_ren,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_ren,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic {
        NORMAL    = 1'b0,
        FORCE_VGA = 1'b1
    } state_t;

    // Counter value at which one more lost cycle forces a VGA grant.
    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    state_t                state;
    state_t                state_next;
    logic [3:0]            wait_cnt;
    logic [3:0]            wait_cnt_next;
    logic [RD_LATENCY-1:0] cpu_pipe;
    logic [RD_LATENCY-1:0] cpu_pipe_next;
    logic [RD_LATENCY-1:0] vga_pipe;
    logic [RD_LATENCY-1:0] vga_pipe_next;

    logic cpu_req;
    logic cpu_rd;
    logic cpu_acc;

    // A simultaneous read+write is treated as a write only.
    assign cpu_req = cpu_ren | cpu_wren;
    assign cpu_rd  = cpu_ren & ~cpu_wren;

    // State register: FSM, starvation counter and read-owner pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= NORMAL;
            wait_cnt <= '0;
            cpu_pipe <= '0;
            vga_pipe <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            cpu_pipe <= cpu_pipe_next;
            vga_pipe <= vga_pipe_next;
        end
    end

    // Next-state logic: count cycles a pending VGA request loses, force it after MAX_WAIT.
    always_comb begin
        state_next    = NORMAL;
        wait_cnt_next = '0;
        if (vga_req && !vga_gnt) begin
            if (wait_cnt == WAIT_LAST) begin
                state_next = FORCE_VGA;
            end else begin
                wait_cnt_next = wait_cnt + 4'd1;
            end
        end
    end

    // Output logic: pick the winner for this cycle; everything is held off during reset.
    always_comb begin
        vga_gnt   = 1'b0;
        cpu_acc   = 1'b0;
        cpu_stall = 1'b0;
        if (!rst) begin
            if (state == FORCE_VGA && vga_req) begin
                vga_gnt   = 1'b1;
                cpu_stall = cpu_req;
            end else if (cpu_req) begin
                cpu_acc = 1'b1;
            end else begin
                vga_gnt = vga_req;
            end
        end
    end

    // Owner pipeline input: who issued the read accepted this cycle.
    always_comb begin
        cpu_pipe_next    = cpu_pipe << 1;
        vga_pipe_next    = vga_pipe << 1;
        cpu_pipe_next[0] = cpu_acc & cpu_rd;
        vga_pipe_next[0] = vga_gnt;
    end

    assign ram_addr  = vga_gnt ? vga_addr : cpu_addr;
    assign ram_wdata = cpu_wdata;
    assign ram_wren  = cpu_acc & cpu_wren;
    assign ram_ren   = (cpu_acc & cpu_rd) | vga_gnt;

    assign cpu_rvalid = cpu_pipe[RD_LATENCY-1];
    assign vga_rvalid = vga_pipe[RD_LATENCY-1];
    assign cpu_rdata  = cpu_rvalid ? ram_q : '0;
    assign vga_rdata  = vga_rvalid ? ram_q : '0;

endmodule

// File: tb/tb_dmem_porta_arbiter.sv
// tb_dmem_porta_arbiter
// Drives the arbiter against a behavioural RAM and compares it with a
// transaction-level model: per-cycle winner, losses-since-last-grant count,
// and a queue of expected read returns stamped with their due cycle.

module tb_dmem_porta_arbiter;

    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 4;

    logic        clk;
    logic        rst;
    logic        cpu_ren, cpu_wren;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        cpu_stall, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic        vga_gnt, vga_rvalid;
    logic [15:0] vga_rdata;
    logic [15:0] ram_addr, ram_wdata, ram_q;
    logic        ram_ren, ram_wren;

    dmem_porta_arbiter #(
        .ADDR_W(16), .DATA_W(16), .RD_LATENCY(RD_LAT), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_ren(cpu_ren), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_ren(ram_ren), .ram_wren(ram_wren),
        .ram_q(ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of a never-written RAM word.
    function automatic logic [15:0] ram_default(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'hA5A5);
    endfunction

    // Behavioural port-A RAM with RD_LAT cycles of read latency.
    logic [15:0] ram_mem [0:65535];
    bit          written [0:65535];
    logic [15:0] q_line  [RD_LAT];

    always @(posedge clk) begin
        if (ram_wren) begin
            ram_mem[ram_addr] <= ram_wdata;
            written[ram_addr] <= 1'b1;
        end
        q_line[0] <= written[ram_addr] ? ram_mem[ram_addr] : ram_default(ram_addr);
        for (int i = 1; i < RD_LAT; i++) q_line[i] <= q_line[i-1];
    end
    assign ram_q = q_line[RD_LAT-1];

    // Reference model state
    typedef struct {
        int          due;
        bit          is_vga;
        logic [15:0] data;
    } resp_t;

    resp_t       exp_q[$];
    logic [15:0] ref_mem [0:65535];
    int          total, bad, cyc, losses;
    bit          model_force, model_init, chk_rv;
    bit          exp_gnt, exp_stall, exp_ren, exp_wren, exp_crv, exp_vrv;
    logic [15:0] exp_addr, exp_rdata;

    // Drive one cycle of inputs, then compute what the model expects for it.
    task automatic step(input bit r, input bit ren, input bit wren, input logic [15:0] ca,
                        input logic [15:0] wd, input bit vr, input logic [15:0] va);
        bit    creq, crd, cacc;
        resp_t e;
        @(posedge clk);
        #1;
        rst = r; cpu_ren = ren; cpu_wren = wren; cpu_addr = ca; cpu_wdata = wd;
        vga_req = vr; vga_addr = va;
        @(negedge clk);
        cyc++;
        creq = ren | wren;
        crd  = ren & !wren;
        exp_gnt = 0; exp_stall = 0; cacc = 0;
        if (!r) begin
            if (model_force && vr) begin
                exp_gnt   = 1;
                exp_stall = creq;
            end else if (creq) begin
                cacc = 1;
            end else begin
                exp_gnt = vr;
            end
        end
        exp_ren  = (cacc && crd) || exp_gnt;
        exp_wren = cacc && wren;
        exp_addr = exp_gnt ? va : ca;
        chk_rv = model_init;
        exp_crv = 0; exp_vrv = 0; exp_rdata = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            exp_crv   = !e.is_vga;
            exp_vrv   = e.is_vga;
            exp_rdata = e.data;
        end
        if (r) begin
            exp_q.delete();
            losses      = 0;
            model_force = 0;
            model_init  = 1;
        end else begin
            if (cacc && crd) begin
                e.due = cyc + RD_LAT; e.is_vga = 0; e.data = ref_mem[ca];
                exp_q.push_back(e);
            end
            if (exp_gnt) begin
                e.due = cyc + RD_LAT; e.is_vga = 1; e.data = ref_mem[va];
                exp_q.push_back(e);
            end
            if (cacc && wren) ref_mem[ca] = wd;
            model_force = 0;
            if (vr && !exp_gnt) begin
                losses++;
                if (losses >= MAX_WAIT) begin
                    model_force = 1;
                    losses      = 0;
                end
            end else begin
                losses = 0;
            end
        end
    endtask

    // Reset holds off every grant/enable and clears read returns.
    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 16'h0001, 16'h0, 1, 16'h0002);
            total++; if (vga_gnt !== 1'b0) begin bad++; $display("[TB] FAIL reset_gnt cyc=%0d got=%b want=0", cyc, vga_gnt); end
            total++; if (cpu_stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall cyc=%0d got=%b want=0", cyc, cpu_stall); end
            total++; if (ram_ren !== 1'b0 || ram_wren !== 1'b0) begin bad++; $display("[TB] FAIL reset_ram_en cyc=%0d got ren=%b wren=%b want 0/0", cyc, ram_ren, ram_wren); end
            if (i > 0) begin
                total++; if (cpu_rvalid !== 1'b0 || vga_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rvalid cyc=%0d got cpu=%b vga=%b want 0/0", cyc, cpu_rvalid, vga_rvalid); end
            end
        end
        step(0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        total++; if (cpu_rvalid !== 1'b0 || vga_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_rvalid got cpu=%b vga=%b want 0/0", cpu_rvalid, vga_rvalid); end
    endtask

    // A lone CPU read in cycle 5 returns its data in cycle 7 only.
    task automatic test_cpu_read();
        for (int i = 1; i <= 9; i++) begin
            step(0, i == 5, 0, 16'h0010, 16'h0, 0, 16'h0);
            total++; if (cpu_rvalid !== (i == 7)) begin bad++; $display("[TB] FAIL cpu_read_rvalid i=%0d got=%b want=%b", i, cpu_rvalid, i == 7); end
            total++; if (vga_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL cpu_read_vga_rvalid i=%0d got=%b want=0", i, vga_rvalid); end
            if (i == 7) begin
                total++; if (cpu_rdata !== 16'hBEEF) begin bad++; $display("[TB] FAIL cpu_read_data got=%h want=beef", cpu_rdata); end
            end
        end
    endtask

    // CPU wins a simultaneous request; VGA is granted once the CPU goes idle.
    task automatic test_simultaneous();
        step(0, 1, 0, 16'h0011, 16'h0, 1, 16'h0004);
        total++; if (vga_gnt !== 1'b0 || ram_ren !== 1'b1 || ram_addr !== 16'h0011) begin bad++; $display("[TB] FAIL simul_cpu_wins got gnt=%b ren=%b addr=%h want 0/1/0011", vga_gnt, ram_ren, ram_addr); end
        step(0, 0, 0, 16'h0011, 16'h0, 1, 16'h0004);
        total++; if (vga_gnt !== 1'b1 || ram_addr !== 16'h0004) begin bad++; $display("[TB] FAIL simul_vga_next got gnt=%b addr=%h want 1/0004", vga_gnt, ram_addr); end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
            total++; if (cpu_rvalid !== exp_crv || vga_rvalid !== exp_vrv) begin bad++; $display("[TB] FAIL simul_rvalid cyc=%0d got cpu=%b vga=%b want %b/%b", cyc, cpu_rvalid, vga_rvalid, exp_crv, exp_vrv); end
        end
    endtask

    // Continuous CPU reads starve VGA for MAX_WAIT cycles, then one forced grant.
    task automatic test_starvation();
        logic [7:0] seq;
        int         n;
        seq = '0; n = 0;
        for (int i = 1; i <= 10; i++) begin
            step(0, i <= 6, 0, 16'h0020 + 16'((i <= 5) ? i : 5), 16'h0, i <= 5, 16'h0007);
            if (i <= 6) begin
                total++; if (vga_gnt !== (i == 5)) begin bad++; $display("[TB] FAIL starve_gnt i=%0d got=%b want=%b", i, vga_gnt, i == 5); end
                total++; if (cpu_stall !== (i == 5)) begin bad++; $display("[TB] FAIL starve_stall i=%0d got=%b want=%b", i, cpu_stall, i == 5); end
            end
            if (cpu_rvalid || vga_rvalid) begin
                seq = {seq[6:0], vga_rvalid};
                n++;
                total++; if ((cpu_rvalid ? cpu_rdata : vga_rdata) !== exp_rdata) begin bad++; $display("[TB] FAIL starve_data cyc=%0d got=%h want=%h", cyc, cpu_rvalid ? cpu_rdata : vga_rdata, exp_rdata); end
            end
        end
        total++; if (n !== 6 || seq[5:0] !== 6'b000010) begin bad++; $display("[TB] FAIL starve_order got n=%0d seq=%b want n=6 seq=000010", n, seq[5:0]); end
    endtask

    // ren+wren together is a write with no read return.
    task automatic test_ren_wren();
        step(0, 1, 1, 16'h0003, 16'h1234, 0, 16'h0);
        total++; if (ram_wren !== 1'b1 || ram_ren !== 1'b0) begin bad++; $display("[TB] FAIL rw_enables got wren=%b ren=%b want 1/0", ram_wren, ram_ren); end
        total++; if (ram_addr !== 16'h0003 || ram_wdata !== 16'h1234) begin bad++; $display("[TB] FAIL rw_bus got addr=%h data=%h want 0003/1234", ram_addr, ram_wdata); end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
            total++; if (cpu_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL rw_no_rvalid i=%0d got=%b want=0", i, cpu_rvalid); end
        end
        for (int i = 0; i <= 2; i++) begin
            step(0, i == 0, 0, 16'h0003, 16'h0, 0, 16'h0);
            if (i == 2) begin
                total++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h1234) begin bad++; $display("[TB] FAIL rw_readback got rv=%b data=%h want 1/1234", cpu_rvalid, cpu_rdata); end
            end
        end
    endtask

    // Alternating CPU/VGA reads each cycle come back to the right owner.
    task automatic test_back_to_back();
        int nc, nv;
        nc = 0; nv = 0;
        for (int i = 0; i < 11; i++) begin
            step(0, i < 8 && i % 2 == 0, 0, 16'h0040 + 16'(i), 16'h0,
                 i < 8 && i % 2 == 1, 16'h0050 + 16'(i));
            total++; if (cpu_rvalid && vga_rvalid) begin bad++; $display("[TB] FAIL b2b_both cyc=%0d got both rvalid high want at most one", cyc); end
            total++; if (cpu_rvalid !== exp_crv || vga_rvalid !== exp_vrv) begin bad++; $display("[TB] FAIL b2b_owner cyc=%0d got cpu=%b vga=%b want %b/%b", cyc, cpu_rvalid, vga_rvalid, exp_crv, exp_vrv); end
            if (exp_crv) begin
                nc++;
                total++; if (cpu_rdata !== exp_rdata) begin bad++; $display("[TB] FAIL b2b_cpu_data cyc=%0d got=%h want=%h", cyc, cpu_rdata, exp_rdata); end
            end
            if (exp_vrv) begin
                nv++;
                total++; if (vga_rdata !== exp_rdata) begin bad++; $display("[TB] FAIL b2b_vga_data cyc=%0d got=%h want=%h", cyc, vga_rdata, exp_rdata); end
            end
        end
        total++; if (nc != 4 || nv != 4) begin bad++; $display("[TB] FAIL b2b_count got cpu=%0d vga=%0d want 4/4", nc, nv); end
    endtask

    // Reset right after a VGA grant drops that read and leaves the FSM in NORMAL.
    task automatic test_reset_mid_read();
        step(0, 0, 0, 16'h0, 16'h0, 1, 16'h0009);
        total++; if (vga_gnt !== 1'b1) begin bad++; $display("[TB] FAIL midrst_grant got=%b want=1", vga_gnt); end
        step(1, 1, 0, 16'h0012, 16'h0, 1, 16'h0009);
        total++; if (vga_gnt !== 1'b0 || cpu_stall !== 1'b0) begin bad++; $display("[TB] FAIL midrst_gnt_in_rst got gnt=%b stall=%b want 0/0", vga_gnt, cpu_stall); end
        step(0, 1, 0, 16'h0012, 16'h0, 1, 16'h0009);
        total++; if (vga_gnt !== 1'b0 || cpu_stall !== 1'b0 || ram_ren !== 1'b1) begin bad++; $display("[TB] FAIL midrst_normal got gnt=%b stall=%b ren=%b want 0/0/1", vga_gnt, cpu_stall, ram_ren); end
        total++; if (vga_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_dropped got=%b want=0", vga_rvalid); end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
            total++; if (vga_rvalid !== 1'b0 || cpu_rvalid !== exp_crv) begin bad++; $display("[TB] FAIL midrst_after i=%0d got vga=%b cpu=%b want 0/%b", i, vga_rvalid, cpu_rvalid, exp_crv); end
        end
    endtask

    // Random mixed traffic with occasional resets, checked cycle by cycle.
    task automatic test_random();
        bit   r, ren, wren, vr, vpend;
        int   p;
        logic [15:0] ca, wd, va;
        vpend = 0; va = 16'h0;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 59) == 0);
            p = $urandom_range(0, 19);
            ren  = (p < 14) || (p == 19);
            wren = (p >= 11 && p < 14) || (p == 19);
            if (p >= 11 && p < 14) ren = 0;
            ca = 16'($urandom_range(0, 31));
            wd = 16'($urandom);
            if (!vpend) begin
                vpend = ($urandom_range(0, 1) == 1);
                va    = 16'($urandom_range(0, 31));
            end
            vr = vpend;
            step(r, ren, wren, ca, wd, vr, va);
            if (exp_gnt || r) vpend = 0;
            total++; if (vga_gnt !== exp_gnt || cpu_stall !== exp_stall) begin bad++; $display("[TB] FAIL rnd_arb cyc=%0d got gnt=%b stall=%b want %b/%b", cyc, vga_gnt, cpu_stall, exp_gnt, exp_stall); end
            total++; if (ram_ren !== exp_ren || ram_wren !== exp_wren || ram_addr !== exp_addr) begin bad++; $display("[TB] FAIL rnd_port cyc=%0d got ren=%b wren=%b addr=%h want %b/%b/%h", cyc, ram_ren, ram_wren, ram_addr, exp_ren, exp_wren, exp_addr); end
            if (exp_wren) begin
                total++; if (ram_wdata !== wd) begin bad++; $display("[TB] FAIL rnd_wdata cyc=%0d got=%h want=%h", cyc, ram_wdata, wd); end
            end
            if (chk_rv) begin
                total++; if (cpu_rvalid !== exp_crv || vga_rvalid !== exp_vrv) begin bad++; $display("[TB] FAIL rnd_rvalid cyc=%0d got cpu=%b vga=%b want %b/%b", cyc, cpu_rvalid, vga_rvalid, exp_crv, exp_vrv); end
                if (exp_crv) begin
                    total++; if (cpu_rdata !== exp_rdata) begin bad++; $display("[TB] FAIL rnd_cpu_data cyc=%0d got=%h want=%h", cyc, cpu_rdata, exp_rdata); end
                end
                if (exp_vrv) begin
                    total++; if (vga_rdata !== exp_rdata) begin bad++; $display("[TB] FAIL rnd_vga_data cyc=%0d got=%h want=%h", cyc, vga_rdata, exp_rdata); end
                end
            end
        end
    endtask

    // Test sequence
    initial begin
        total = 0; bad = 0; cyc = 0; losses = 0;
        model_force = 0; model_init = 0;
        for (int a = 0; a < 65536; a++) ref_mem[a] = ram_default(16'(a));
        rst = 1; cpu_ren = 0; cpu_wren = 0; cpu_addr = '0; cpu_wdata = '0;
        vga_req = 0; vga_addr = '0;
        test_reset();
        test_cpu_read();
        test_simultaneous();
        test_starvation();
        test_ren_wren();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
